// File: rtl/wl_div_pkg.sv
// wl_div_pkg: shared state encoding and default widths for wl_seq_div.
package wl_div_pkg;
    localparam int DIV_DW = 36;
    localparam int DIV_VW = 18;
    localparam int DIV_CW = 6;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2,
        ST_FIX  = 2'd3
    } state_t;
endpackage

// File: rtl/wl_seq_div_if.sv
// wl_seq_div_if: valid/ready operand and result bundle for wl_seq_div.
interface wl_seq_div_if import wl_div_pkg::*; #(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
);
    logic          in_valid, in_ready, out_valid, out_ready, div_zero;
    logic [DW-1:0] dividend, quotient;
    logic [VW-1:0] divisor, remainder;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/wl_div_step.sv
// wl_div_step: one radix-2 restoring step (shift in, compare, subtract, quotient bit).
module wl_div_step #(
    parameter int VW = 18
) (
    input  logic [VW:0]   r,
    input  logic          q_msb,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   r_nxt,
    output logic          q_bit
);
    logic [VW+1:0] t;
    assign t     = {r, q_msb};
    assign q_bit = t >= {2'b00, divisor};
    assign r_nxt = (VW+1)'(q_bit ? t - {2'b00, divisor} : t);
endmodule

// File: rtl/wl_seq_div.sv
// wl_seq_div: iterative radix-2 restoring divider, one bit per cycle, valid/ready on both sides.
// WL_SEQ_DIV_SIGNED_EN selects two's complement operands with a sign-fix cycle.
module wl_seq_div import wl_div_pkg::*; #(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW,
    parameter int CW = DIV_CW
) (
    input logic         clk,
    input logic         rst_n,
    wl_seq_div_if.slave bus
);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] q_sh, q_fin;
    logic [VW-1:0] dvs;
    logic [VW:0]   r, r_nxt;
    logic          q_bit;
`ifdef WL_SEQ_DIV_SIGNED_EN
    logic          sign_q, sign_r;
`endif

    wl_div_step #(.VW(VW)) u_step (
        .r(r), .q_msb(q_sh[DW-1]), .divisor(dvs), .r_nxt(r_nxt), .q_bit(q_bit)
    );

    assign q_fin = {q_sh[DW-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.div_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid && bus.in_ready) begin
`ifdef WL_SEQ_DIV_SIGNED_EN
                    q_sh   <= bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
                    dvs    <= bus.divisor[VW-1] ? -bus.divisor : bus.divisor;
                    sign_q <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                    sign_r <= bus.dividend[DW-1];
`else
                    q_sh   <= bus.dividend;
                    dvs    <= bus.divisor;
`endif
                    r            <= '0;
                    cnt          <= '0;
                    bus.div_zero <= bus.divisor == '0;
                    bus.in_ready <= 1'b0;
                    state        <= ST_CALC;
                end
                ST_CALC: begin
                    q_sh <= q_fin;
                    r    <= r_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
`ifdef WL_SEQ_DIV_SIGNED_EN
                        state <= ST_FIX;
`else
                        bus.quotient  <= bus.div_zero ? '1 : q_fin;
                        bus.remainder <= bus.div_zero ? '0 : r_nxt[VW-1:0];
                        bus.out_valid <= 1'b1;
                        state         <= ST_DONE;
`endif
                    end
                end
`ifdef WL_SEQ_DIV_SIGNED_EN
                ST_FIX: begin
                    bus.quotient  <= bus.div_zero ? '1 : (sign_q ? -q_sh : q_sh);
                    bus.remainder <= bus.div_zero ? '0 : (sign_r ? -r[VW-1:0] : r[VW-1:0]);
                    bus.out_valid <= 1'b1;
                    state         <= ST_DONE;
                end
`endif
                ST_DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
